// File: rtl/id_stage_if.sv
// id_stage_if: handshake and decoded-operation bus around the ID stage.
//   IF -> ID : if_valid, if_pc, if_inst, id_ready (returned by ID)
//   ID -> EX : id_valid, ex_ready (returned by EX), id_pc, id_aluop,
//              id_opnd1, id_opnd2, id_store_data, id_wd, id_wreg,
//              id_mem_rd, id_mem_wr, id_illegal
// master = the ID stage itself; slave = the surrounding IF/EX environment.
interface id_stage_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          if_valid;
    logic [DW-1:0] if_pc;
    logic [31:0]   if_inst;
    logic          id_ready;

    logic          id_valid;
    logic          ex_ready;
    logic [DW-1:0] id_pc;
    logic [3:0]    id_aluop;
    logic [DW-1:0] id_opnd1;
    logic [DW-1:0] id_opnd2;
    logic [DW-1:0] id_store_data;
    logic [AW-1:0] id_wd;
    logic          id_wreg;
    logic          id_mem_rd;
    logic          id_mem_wr;
    logic          id_illegal;

    modport master (
        input  if_valid, if_pc, if_inst, ex_ready,
        output id_ready, id_valid, id_pc, id_aluop, id_opnd1, id_opnd2,
               id_store_data, id_wd, id_wreg, id_mem_rd, id_mem_wr, id_illegal
    );

    modport slave (
        output if_valid, if_pc, if_inst, ex_ready,
        input  id_ready, id_valid, id_pc, id_aluop, id_opnd1, id_opnd2,
               id_store_data, id_wd, id_wreg, id_mem_rd, id_mem_wr, id_illegal
    );
endinterface

// File: rtl/id_stage.sv
// id_stage: instruction-decode stage of the 5-stage MIPS-subset pipeline.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   bus (master)        IF->ID and ID->EX handshakes plus decoded outputs
//   re1/raddr1/rdata1   regfile read port 1 (registered read, 1-cycle latency)
//   re2/raddr2/rdata2   regfile read port 2
//   ex_fwd_*            result being produced in EX, ex_is_load marks an LW
//   mem_fwd_*           result sitting in MEM
// A one-entry stage: EMPTY/FULL state plus a bank of decoded fields. Operands
// are resolved combinationally from the regfile data and the forwarding paths.
module id_stage #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    id_stage_if.master    bus,
    output logic          re1,
    output logic [AW-1:0] raddr1,
    input  logic [DW-1:0] rdata1,
    output logic          re2,
    output logic [AW-1:0] raddr2,
    input  logic [DW-1:0] rdata2,
    input  logic          ex_fwd_we,
    input  logic [AW-1:0] ex_fwd_waddr,
    input  logic [DW-1:0] ex_fwd_wdata,
    input  logic          ex_is_load,
    input  logic          mem_fwd_we,
    input  logic [AW-1:0] mem_fwd_waddr,
    input  logic [DW-1:0] mem_fwd_wdata
);

    localparam logic [3:0] ALU_NOP = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_XOR = 4'd3;
    localparam logic [3:0] ALU_ADD = 4'd4;
    localparam logic [3:0] ALU_SUB = 4'd5;
    localparam logic [3:0] ALU_SLT = 4'd6;
    localparam logic [3:0] ALU_LUI = 4'd7;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t        state;
    logic [DW-1:0] pc_q;
    logic [AW-1:0] rs_q, rt_q, wd_q;
    logic [DW-1:0] imm_q;
    logic [3:0]    aluop_q;
    logic          wreg_q, mem_rd_q, mem_wr_q, illegal_q;
    logic          use_rs_q, use_rt_q, use_imm_q;

    logic [5:0]    op, funct;
    logic [AW-1:0] f_rs, f_rt, f_rd;
    logic [DW-1:0] d_imm;
    logic [AW-1:0] d_wd;
    logic [3:0]    d_aluop;
    logic          d_wreg, d_mem_rd, d_mem_wr, d_illegal;
    logic          d_use_rs, d_use_rt, d_use_imm;

    logic          load_use, valid, ready, accept, fire;
    logic [DW-1:0] src1, src2;

    assign op    = bus.if_inst[31:26];
    assign funct = bus.if_inst[5:0];
    assign f_rs  = bus.if_inst[25:21];
    assign f_rt  = bus.if_inst[20:16];
    assign f_rd  = bus.if_inst[15:11];

    // Decode of the incoming instruction word; the result is only captured on accept.
    always_comb begin
        d_aluop   = ALU_NOP;
        d_imm     = '0;
        d_wd      = '0;
        d_wreg    = 1'b0;
        d_mem_rd  = 1'b0;
        d_mem_wr  = 1'b0;
        d_illegal = 1'b0;
        d_use_rs  = 1'b0;
        d_use_rt  = 1'b0;
        d_use_imm = 1'b0;
        case (op)
            6'h00: begin
                d_use_rs = 1'b1;
                d_use_rt = 1'b1;
                d_wd     = f_rd;
                d_wreg   = 1'b1;
                case (funct)
                    6'h25:   d_aluop = ALU_OR;
                    6'h24:   d_aluop = ALU_AND;
                    6'h26:   d_aluop = ALU_XOR;
                    6'h21:   d_aluop = ALU_ADD;
                    6'h23:   d_aluop = ALU_SUB;
                    6'h2A:   d_aluop = ALU_SLT;
                    default: d_illegal = 1'b1;
                endcase
            end
            6'h0D, 6'h0C, 6'h0E: begin
                d_aluop   = (op == 6'h0D) ? ALU_OR : (op == 6'h0C) ? ALU_AND : ALU_XOR;
                d_use_rs  = 1'b1;
                d_use_imm = 1'b1;
                d_imm     = {{(DW-16){1'b0}}, bus.if_inst[15:0]};
                d_wd      = f_rt;
                d_wreg    = 1'b1;
            end
            6'h09, 6'h23: begin
                d_aluop   = ALU_ADD;
                d_use_rs  = 1'b1;
                d_use_imm = 1'b1;
                d_imm     = {{(DW-16){bus.if_inst[15]}}, bus.if_inst[15:0]};
                d_wd      = f_rt;
                d_wreg    = 1'b1;
                d_mem_rd  = (op == 6'h23);
            end
            6'h0F: begin
                d_aluop   = ALU_LUI;
                d_use_imm = 1'b1;
                d_imm     = {bus.if_inst[15:0], {(DW-16){1'b0}}};
                d_wd      = f_rt;
                d_wreg    = 1'b1;
            end
            6'h2B: begin
                d_aluop   = ALU_ADD;
                d_use_rs  = 1'b1;
                d_use_rt  = 1'b1;
                d_use_imm = 1'b1;
                d_imm     = {{(DW-16){bus.if_inst[15]}}, bus.if_inst[15:0]};
                d_mem_wr  = 1'b1;
            end
            default: d_illegal = 1'b1;
        endcase
        // An illegal instruction still flows down the pipe, but as a pure no-op.
        if (d_illegal) begin
            d_aluop   = ALU_NOP;
            d_wd      = '0;
            d_wreg    = 1'b0;
            d_mem_rd  = 1'b0;
            d_mem_wr  = 1'b0;
            d_use_rs  = 1'b0;
            d_use_rt  = 1'b0;
            d_use_imm = 1'b0;
            d_imm     = '0;
        end
        if (d_wd == '0) begin
            d_wreg = 1'b0;
        end
    end

    // A load in EX cannot forward yet, so a dependent held instruction must wait.
    assign load_use = (state == FULL) && ex_is_load && ex_fwd_we && (ex_fwd_waddr != '0) &&
                      ((use_rs_q && ex_fwd_waddr == rs_q) || (use_rt_q && ex_fwd_waddr == rt_q));
    assign valid  = (state == FULL) && !load_use;
    assign ready  = (state == EMPTY) || (valid && bus.ex_ready);
    assign accept = bus.if_valid && ready;
    assign fire   = valid && bus.ex_ready;

    // Read addresses follow the incoming word on accept, else the held fields, so a
    // held instruction re-reads every cycle and sees writes retiring meanwhile.
    assign raddr1 = accept ? f_rs : rs_q;
    assign raddr2 = accept ? f_rt : rt_q;
    assign re1    = !rst && (accept ? d_use_rs : use_rs_q);
    assign re2    = !rst && (accept ? d_use_rt : use_rt_q);

    function automatic logic [DW-1:0] resolve(
        input logic [AW-1:0] a,   input logic [DW-1:0] rd,
        input logic          xwe, input logic [AW-1:0] xa, input logic [DW-1:0] xd,
        input logic          mwe, input logic [AW-1:0] ma, input logic [DW-1:0] md
    );
        if (a == '0)                 return '0;
        else if (xwe && xa == a)     return xd;
        else if (mwe && ma == a)     return md;
        else                         return rd;
    endfunction

    assign src1 = resolve(rs_q, rdata1, ex_fwd_we, ex_fwd_waddr, ex_fwd_wdata,
                          mem_fwd_we, mem_fwd_waddr, mem_fwd_wdata);
    assign src2 = resolve(rt_q, rdata2, ex_fwd_we, ex_fwd_waddr, ex_fwd_wdata,
                          mem_fwd_we, mem_fwd_waddr, mem_fwd_wdata);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            pc_q      <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            wd_q      <= '0;
            imm_q     <= '0;
            aluop_q   <= ALU_NOP;
            wreg_q    <= 1'b0;
            mem_rd_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            illegal_q <= 1'b0;
            use_rs_q  <= 1'b0;
            use_rt_q  <= 1'b0;
            use_imm_q <= 1'b0;
        end else if (accept) begin
            state     <= FULL;
            pc_q      <= bus.if_pc;
            rs_q      <= f_rs;
            rt_q      <= f_rt;
            wd_q      <= d_wd;
            imm_q     <= d_imm;
            aluop_q   <= d_aluop;
            wreg_q    <= d_wreg;
            mem_rd_q  <= d_mem_rd;
            mem_wr_q  <= d_mem_wr;
            illegal_q <= d_illegal;
            use_rs_q  <= d_use_rs;
            use_rt_q  <= d_use_rt;
            use_imm_q <= d_use_imm;
        end else if (fire) begin
            state <= EMPTY;
        end
    end

    assign bus.id_ready      = ready;
    assign bus.id_valid      = valid;
    assign bus.id_pc         = pc_q;
    assign bus.id_aluop      = aluop_q;
    assign bus.id_opnd1      = use_rs_q ? src1 : '0;
    assign bus.id_opnd2      = use_imm_q ? imm_q : (use_rt_q ? src2 : '0);
    assign bus.id_store_data = use_rt_q ? src2 : '0;
    assign bus.id_wd         = wd_q;
    assign bus.id_wreg       = wreg_q;
    assign bus.id_mem_rd     = mem_rd_q;
    assign bus.id_mem_wr     = mem_wr_q;
    assign bus.id_illegal    = illegal_q;

endmodule
